// File: rtl/key_event_decoder.sv
// key_event_decoder
//
// Turns a debounced, clock-synchronous key level into discrete events:
// SHORT press, LONG press, hold REPEAT and DOUBLE click. One event is held
// at a time for a consumer on a valid/ready handshake. All thresholds are
// runtime-configurable and counted in clock cycles.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   key_in        debounced key level (PRESS_LVL means pressed)
//   cfg_long_cnt  pressed samples for LONG (clamped to >= 2)
//   cfg_gap_cnt   released samples after which a single press is final (clamped to >= 2)
//   cfg_rpt_cnt   repeat period while held in LONG (0 disables)
//   evt_valid     an event is pending
//   evt_code      0 REPEAT, 1 SHORT, 2 LONG, 3 DOUBLE
//   evt_ready     consumer accepts the pending event
//   evt_ovf       sticky: an event was dropped
//   busy          FSM is not idle
module key_event_decoder #(
    parameter logic        PRESS_LVL = 1'b0,
    parameter int unsigned CNT_WID   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_in,
    input  logic [CNT_WID-1:0] cfg_long_cnt,
    input  logic [CNT_WID-1:0] cfg_gap_cnt,
    input  logic [CNT_WID-1:0] cfg_rpt_cnt,
    output logic               evt_valid,
    output logic [1:0]         evt_code,
    input  logic               evt_ready,
    output logic               evt_ovf,
    output logic               busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPress1 = 3'd1;
    localparam logic [2:0] StWait2  = 3'd2;
    localparam logic [2:0] StPress2 = 3'd3;
    localparam logic [2:0] StLong   = 3'd4;

    localparam logic [1:0] EvtRepeat = 2'd0;
    localparam logic [1:0] EvtShort  = 2'd1;
    localparam logic [1:0] EvtLong   = 2'd2;
    localparam logic [1:0] EvtDouble = 2'd3;

    localparam logic [CNT_WID-1:0] CntTwo = CNT_WID'(2);
    localparam logic [CNT_WID-1:0] CntOne = CNT_WID'(1);

    logic [2:0]         state_q, state_d;
    logic [CNT_WID-1:0] cnt_q, cnt_d, cnt_inc;
    logic               armed_q, armed_d;
    logic               evt_valid_q, evt_valid_d;
    logic [1:0]         evt_code_q, evt_code_d;
    logic               evt_ovf_q, evt_ovf_d;

    logic               pressed;
    logic [CNT_WID-1:0] long_lim, gap_lim;
    logic               emit;
    logic [1:0]         emit_code;

    assign pressed  = (key_in == PRESS_LVL);
    assign cnt_inc  = cnt_q + CntOne;
    assign long_lim = (cfg_long_cnt < CntTwo) ? CntTwo : cfg_long_cnt;
    assign gap_lim  = (cfg_gap_cnt < CntTwo) ? CntTwo : cfg_gap_cnt;

    // A key held through reset must be released once before it can start a press.
    assign armed_d = armed_q | ~pressed;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = EvtRepeat;
        unique case (state_q)
            StIdle: begin
                if (pressed && armed_q) begin
                    state_d = StPress1;
                    cnt_d   = CntOne;
                end
            end
            StPress1: begin
                if (pressed) begin
                    if (cnt_inc == long_lim) begin
                        emit      = 1'b1;
                        emit_code = EvtLong;
                        state_d   = StLong;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = StWait2;
                    cnt_d   = CntOne;
                end
            end
            StWait2: begin
                if (pressed) begin
                    state_d = StPress2;
                end else if (cnt_inc == gap_lim) begin
                    emit      = 1'b1;
                    emit_code = EvtShort;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StPress2: begin
                if (!pressed) begin
                    emit      = 1'b1;
                    emit_code = EvtDouble;
                    state_d   = StIdle;
                end
            end
            StLong: begin
                if (pressed) begin
                    if ((cfg_rpt_cnt != '0) && (cnt_inc == cfg_rpt_cnt)) begin
                        emit      = 1'b1;
                        emit_code = EvtRepeat;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Single-entry event register; a new event may replace one being accepted
    // in the same cycle, otherwise it is dropped and flagged.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_ovf_d   = evt_ovf_q;
        if (emit) begin
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d = 1'b1;
                evt_code_d  = emit_code;
            end else begin
                evt_ovf_d = 1'b1;
            end
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 2'd0;
            evt_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_ovf_q   <= evt_ovf_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_ovf   = evt_ovf_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: a run-length model of the key gesture rules
// checked every cycle, plus literal event/timing expectations per scenario.
module tb_key_event_decoder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_in = 1'b1;
    logic         evt_ready = 1'b1;
    logic [W-1:0] cfg_long_cnt = 8'd10;
    logic [W-1:0] cfg_gap_cnt = 8'd6;
    logic [W-1:0] cfg_rpt_cnt = 8'd4;
    logic         evt_valid;
    logic [1:0]   evt_code;
    logic         evt_ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int log_code[$];
    int log_cyc[$];

    key_event_decoder #(
        .PRESS_LVL(1'b0),
        .CNT_WID  (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .cfg_long_cnt(cfg_long_cnt),
        .cfg_gap_cnt (cfg_gap_cnt),
        .cfg_rpt_cnt (cfg_rpt_cnt),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .evt_ovf     (evt_ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Gesture described by run lengths: held = pressed samples of the current
    // press, rel = released samples since the first press ended.
    bit       m_armed, m_first, m_wait, m_second, m_long;
    int       m_held, m_rel;
    bit       e_valid, e_ovf;
    int       e_code;
    bit       m_emit;
    int       m_code, lim_l, lim_g, per_r;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_armed = 0; m_first = 0; m_wait = 0; m_second = 0; m_long = 0;
            m_held = 0; m_rel = 0;
            e_valid = 0; e_ovf = 0; e_code = 0;
        end else begin
            m_emit = 0;
            m_code = 0;
            lim_l = (int'(cfg_long_cnt) < 2) ? 2 : int'(cfg_long_cnt);
            lim_g = (int'(cfg_gap_cnt) < 2) ? 2 : int'(cfg_gap_cnt);
            per_r = int'(cfg_rpt_cnt);
            if (!m_armed) begin
                if (key_in) m_armed = 1;
            end else if (!key_in) begin
                if (m_long) begin
                    m_held++;
                    if (per_r != 0 && ((m_held - lim_l) % per_r) == 0) begin
                        m_emit = 1; m_code = 0;
                    end
                end else if (m_second) begin
                    // second press of a double: no long detection
                end else if (m_wait) begin
                    m_wait = 0; m_second = 1;
                end else if (m_first) begin
                    m_held++;
                    if (m_held == lim_l) begin
                        m_emit = 1; m_code = 2; m_first = 0; m_long = 1;
                    end
                end else begin
                    m_first = 1; m_held = 1;
                end
            end else begin
                if (m_long) begin
                    m_long = 0;
                end else if (m_second) begin
                    m_emit = 1; m_code = 3; m_second = 0;
                end else if (m_first) begin
                    m_first = 0; m_wait = 1; m_rel = 1;
                end else if (m_wait) begin
                    m_rel++;
                    if (m_rel == lim_g) begin
                        m_emit = 1; m_code = 1; m_wait = 0;
                    end
                end
            end
            if (m_emit) begin
                if (!e_valid || evt_ready) begin
                    e_valid = 1; e_code = m_code;
                end else begin
                    e_ovf = 1;
                end
            end else if (e_valid && evt_ready) begin
                e_valid = 0;
            end
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    always @(negedge clk) begin
        chk("evt_valid", int'(evt_valid), int'(e_valid));
        chk("evt_code", int'(evt_code), e_code);
        chk("evt_ovf", int'(evt_ovf), int'(e_ovf));
        chk("busy", int'(busy), int'(m_first | m_wait | m_second | m_long));
        if (evt_valid && evt_ready) begin
            log_code.push_back(int'(evt_code));
            log_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic k, input int n);
        repeat (n) begin
            @(negedge clk);
            #1 key_in = k;
        end
    endtask

    task automatic start_seg();
        log_code.delete();
        log_cyc.delete();
        @(negedge clk);
        #1 t0 = cyc;
    endtask

    // Compare logged event i against literal code and latency from segment start.
    task automatic chk_ev(input string name, input int i, input int code, input int dt);
        if (log_code.size() > i) begin
            chk({name, "_code"}, log_code[i], code);
            chk({name, "_time"}, log_cyc[i] - t0, dt);
        end else begin
            chk({name, "_missing"}, log_code.size(), i + 1);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_code", int'(evt_code), 0);
        chk("rst_ovf", int'(evt_ovf), 0);
        chk("rst_busy", int'(busy), 0);
        #1 rst = 1'b0;
        drive(1'b1, 3);

        // 1: short press, first sample driven right after start_seg
        start_seg();
        key_in = 1'b0;
        drive(1'b0, 4);
        drive(1'b1, 10);
        chk("t1_count", log_code.size(), 1);
        chk_ev("t1", 0, 1, 11);

        // 2: long press with repeats
        start_seg();
        key_in = 1'b0;
        drive(1'b0, 19);
        drive(1'b1, 8);
        chk("t2_count", log_code.size(), 3);
        chk_ev("t2_long", 0, 2, 10);
        chk_ev("t2_rpt1", 1, 0, 14);
        chk_ev("t2_rpt2", 2, 0, 18);

        // 3: double click
        start_seg();
        key_in = 1'b0;
        drive(1'b0, 2);
        drive(1'b1, 3);
        drive(1'b0, 3);
        drive(1'b1, 10);
        chk("t3_count", log_code.size(), 1);
        chk_ev("t3", 0, 3, 10);

        // 4: gap too long -> two shorts
        start_seg();
        key_in = 1'b0;
        drive(1'b0, 2);
        drive(1'b1, 6);
        drive(1'b0, 3);
        drive(1'b1, 8);
        chk("t4_count", log_code.size(), 2);
        chk_ev("t4_a", 0, 1, 9);
        chk_ev("t4_b", 1, 1, 18);

        // 5: overflow with consumer stalled, repeat disabled
        cfg_rpt_cnt = 8'd0;
        evt_ready = 1'b0;
        start_seg();
        key_in = 1'b0;
        drive(1'b0, 2);
        drive(1'b1, 6);
        drive(1'b0, 12);
        settle();
        chk("t5_valid", int'(evt_valid), 1);
        chk("t5_code", int'(evt_code), 1);
        chk("t5_ovf", int'(evt_ovf), 1);
        @(negedge clk);
        #1 evt_ready = 1'b1;
        settle();
        chk("t5_drop_valid", int'(evt_valid), 0);
        chk("t5_ovf_sticky", int'(evt_ovf), 1);
        drive(1'b1, 4);
        cfg_rpt_cnt = 8'd4;

        // 6: reset mid-press, key kept pressed through and after reset
        start_seg();
        key_in = 1'b0;
        drive(1'b0, 5);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 14);
        drive(1'b1, 6);
        settle();
        chk("t6_count", log_code.size(), 0);
        chk("t6_ovf", int'(evt_ovf), 0);
        start_seg();
        key_in = 1'b0;
        drive(1'b0, 2);
        drive(1'b1, 8);
        chk("t6_count2", log_code.size(), 1);
        chk_ev("t6_short", 0, 1, 9);

        // 7: long threshold below 2 clamps to 2
        cfg_long_cnt = 8'd0;
        start_seg();
        key_in = 1'b0;
        drive(1'b0, 2);
        drive(1'b1, 8);
        chk("t7_count", log_code.size(), 1);
        chk_ev("t7_long", 0, 2, 2);
        cfg_long_cnt = 8'd10;

        drive(1'b1, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Classifies a debounced, clock-synchronous key level into discrete user events: short press, long press, hold-repeat and double click. It sits directly downstream of the key deglitch stage and takes that stage's filtered output as its input. It presents one event at a time to a consumer over a valid/ready handshake. All thresholds are runtime-configurable and counted in clock cycles.

## Interface
Parameters:
- PRESS_LVL, default 1'b0: input level meaning "pressed". The upstream idle level is 1.
- CNT_WID, default 16: width of the internal counter and of all cfg_* inputs.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: reset. Synchronous, active-high.
- key_in, input, 1: debounced key level from the deglitch stage, already synchronous to clk.
- cfg_long_cnt, input, CNT_WID: L, pressed samples needed for a long press. Values below 2 are treated as 2.
- cfg_gap_cnt, input, CNT_WID: G, released samples after which a single press is final. Values below 2 are treated as 2.
- cfg_rpt_cnt, input, CNT_WID: R, repeat period while held after a long press. 0 disables repeat.
- evt_valid, output, 1: an event is pending.
- evt_code, output, 2: event type. 0 = REPEAT, 1 = SHORT, 2 = LONG, 3 = DOUBLE.
- evt_ready, input, 1: consumer accepts the pending event.
- evt_ovf, output, 1: sticky flag, set when an event was dropped.
- busy, output, 1: FSM is not in IDLE.

## Operation
- A "sample" is the value of key_in at one rising edge. "pressed" means key_in == PRESS_LVL.
- States are IDLE, PRESS1, WAIT2, PRESS2 and LONG. There is one counter, cnt, which is CNT_WID bits wide.
- armed flag:
  - Cleared by reset.
  - Set by the first released sample.
  - While armed=0, IDLE ignores pressed samples.
- IDLE:
  - pressed and armed → PRESS1, cnt=1.
- PRESS1:
  - pressed and cnt+1==L → emit LONG, go to LONG, cnt=0.
  - pressed otherwise → cnt+1.
  - released → WAIT2, cnt=1.
- WAIT2:
  - pressed → PRESS2.
  - released and cnt+1==G → emit SHORT, go to IDLE.
  - released otherwise → cnt+1.
- PRESS2:
  - released → emit DOUBLE, go to IDLE.
  - While held, no long-press detection is performed.
- LONG:
  - pressed, R≠0 and cnt+1==R → emit REPEAT, cnt=0.
  - pressed otherwise → cnt+1.
  - released → IDLE. No event is emitted on release.
- Comparisons are exact equality on CNT_WID bits. Clamped values are computed combinationally from the cfg_* inputs. The cfg_* inputs must be held stable while busy=1; changing them then is undefined.
- Event register (one entry):
  - On emit: if evt_valid=0, or evt_valid=1 with evt_ready=1 in the same cycle, the new event loads and evt_valid=1.
  - Otherwise the new event is dropped, evt_code is unchanged and evt_ovf is set.
  - On evt_valid and evt_ready with no emit: evt_valid clears.
  - evt_ovf clears only on reset.
- Reset mid-operation (any state) has the same effect as reset from idle. No event is emitted for a press that was interrupted by reset.

## Timing
- Reset values:
  - evt_valid=0, evt_code=0, evt_ovf=0, busy=0.
  - state=IDLE, cnt=0, armed=0.
- Event latency: evt_valid and evt_code are registered and assert in the cycle after the triggering sample.
- A press of N consecutive samples:
  - N ≥ L gives LONG, asserted after the L-th pressed sample.
  - N < L followed by G released samples gives SHORT, asserted after the G-th released sample.
- Double click: the second press must arrive at released-run sample index < G, counting the release sample that left PRESS1 as index 1.
- REPEAT fires after pressed samples L+R, L+2R, and so on. With R=1, REPEAT is emitted on every pressed sample in LONG.
- busy is a combinational decode of the state register (state≠IDLE).
- evt_code is held stable while evt_valid=1.

## Test plan
All cases use CNT_WID=8, L=10, G=6, R=4, evt_ready=1, and key idle-high, unless stated otherwise.
1. Press 5 samples, then release 10 → one event, code 1, evt_valid for 1 cycle, asserted the cycle after the 6th released sample. busy falls at the same point.
2. Press 20 samples, then release → code 2 after the 10th pressed sample; code 0 after the 14th and the 18th. Nothing after release.
3. Press 3, release 3, press 3, release → a single code 3, asserted the cycle after the first released sample of the second press. No SHORT is emitted.
4. Press 3, release 6, press 3, release 6 → two separate code 1 events; the second press is treated as a new PRESS1.
5. evt_ready=0, with R=0: press 3, release 6, then press 12 → evt_code stays 1 and evt_ovf=1. Raise evt_ready → evt_valid drops the next cycle, and evt_ovf stays 1.
6. Assert rst for 1 cycle at pressed sample 7 of a press, keep key pressed for 15 more cycles, then release 6 → no events, evt_ovf=0. A following 3-press/6-release sequence yields code 1.
